// File: rtl/data_memory.sv
// rtl/data_memory.sv - single-port word memory shared by a core, a handshaked host port and a background clear engine
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module data_memory #(
    parameter int ADDR_W = `ADDRESS_SIZE,
    parameter int DATA_W = `DATA_SIZE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clear,
    output logic              clear_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } host_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    host_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_ack_q, host_ack_d;
    logic              h_we_q, h_we_d;
    logic [ADDR_W-1:0] h_addr_q, h_addr_d;
    logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
    logic              clear_busy_q, clear_busy_d;
    logic [ADDR_W-1:0] index_q, index_d;

    logic              core_idle;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Next-state logic: core always wins the port; host only runs on core-idle
    // edges, and the clear engine only when neither core nor host is using it.
    always_comb begin
        state_d      = state_q;
        data_in_d    = data_in_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        h_we_d       = h_we_q;
        h_addr_d     = h_addr_q;
        h_wdata_d    = h_wdata_q;
        clear_busy_d = clear_busy_q;
        index_d      = index_q;
        core_idle    = !read && !write;
        mem_we       = write;
        mem_waddr    = address;
        mem_wdata    = data_out;

        // Simultaneous read+write returns the store data (write-through).
        if (read) begin
            data_in_d = write ? data_out : mem[address];
        end

        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d   = ACCESS;
                    h_we_d    = host_we;
                    h_addr_d  = host_addr;
                    h_wdata_d = host_wdata;
                end
            end
            ACCESS: begin
                if (core_idle) begin
                    state_d    = ACK;
                    host_ack_d = 1'b1;
                    if (h_we_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = h_addr_q;
                        mem_wdata = h_wdata_q;
                    end else begin
                        host_rdata_d = mem[h_addr_q];
                    end
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // A fresh request must see host_req drop first.
                if (!host_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!clear_busy_q) begin
            if (clear) begin
                clear_busy_d = 1'b1;
                index_d      = '0;
            end
        end else if (core_idle && (state_q != ACCESS)) begin
            mem_we    = 1'b1;
            mem_waddr = index_q;
            mem_wdata = '0;
            index_d   = index_q + 1'b1;
            if (index_q == {ADDR_W{1'b1}}) begin
                clear_busy_d = 1'b0;
            end
        end
    end

    // Control and output registers; reset aborts any host access or clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            data_in_q    <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            h_we_q       <= 1'b0;
            h_addr_q     <= '0;
            h_wdata_q    <= '0;
            clear_busy_q <= 1'b0;
            index_q      <= '0;
        end else begin
            state_q      <= state_d;
            data_in_q    <= data_in_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            h_we_q       <= h_we_d;
            h_addr_q     <= h_addr_d;
            h_wdata_q    <= h_wdata_d;
            clear_busy_q <= clear_busy_d;
            index_q      <= index_d;
        end
    end

    // Storage array: single write port, contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign data_in    = data_in_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
    assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

    logic        clock;
    logic        reset;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        host_req;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        clear;
    logic        clear_busy;

    int checks = 0;
    int errors = 0;
    int cnt;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[14];

    data_memory #(.ADDR_W(4), .DATA_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .data_out   (data_out),
        .data_in    (data_in),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .clear      (clear),
        .clear_busy (clear_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic core_read(input logic [3:0] a, input logic [15:0] exp, input string name);
        read    = 1'b1;
        address = a;
        step();
        read    = 1'b0;
        chk(name, data_in, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 4'd5,  16'h1234, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 4'd5,  16'h0000, 16'h1234};
        vecs[2]  = '{1'b1, 1'b1, 4'd3,  16'h00AB, 16'h00AB};
        vecs[3]  = '{1'b1, 1'b0, 4'd3,  16'h0000, 16'h00AB};
        vecs[4]  = '{1'b0, 1'b0, 4'd3,  16'h0000, 16'h00AB};
        vecs[5]  = '{1'b0, 1'b1, 4'd15, 16'hBEEF, 16'h00AB};
        vecs[6]  = '{1'b1, 1'b0, 4'd15, 16'h0000, 16'hBEEF};
        vecs[7]  = '{1'b0, 1'b1, 4'd0,  16'h0001, 16'hBEEF};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 16'h0001};
        vecs[9]  = '{1'b0, 1'b1, 4'd7,  16'h5555, 16'h0001};
        vecs[10] = '{1'b1, 1'b0, 4'd7,  16'h0000, 16'h5555};
        vecs[11] = '{1'b1, 1'b0, 4'd5,  16'h0000, 16'h1234};
        vecs[12] = '{1'b1, 1'b1, 4'd15, 16'h0F0F, 16'h0F0F};
        vecs[13] = '{1'b1, 1'b0, 4'd15, 16'h0000, 16'h0F0F};

        reset = 1'b0; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; clear = 1'b0;
        #2;
        chk("reset_data_in", data_in, 16'h0);
        chk("reset_host_ack", host_ack, 1'b0);
        chk("reset_host_rdata", host_rdata, 16'h0);
        chk("reset_clear_busy", clear_busy, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();

        // Core port vectors
        for (int i = 0; i < 14; i++) begin
            read     = vecs[i].rd;
            write    = vecs[i].wr;
            address  = vecs[i].addr;
            data_out = vecs[i].wdata;
            step();
            chk($sformatf("core_vec%0d", i), data_in, vecs[i].exp);
        end
        read = 1'b0; write = 1'b0;
        core_read(4'd3, 16'h00AB, "wt_mem3");

        // Host read held off by 3 cycles of core reads
        read = 1'b1; address = 4'd0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd5;
        step(); chk("hr_ack_a", host_ack, 1'b0); chk("hr_core_data", data_in, 16'h0001);
        step(); chk("hr_ack_b", host_ack, 1'b0);
        step(); chk("hr_ack_c", host_ack, 1'b0);
        read = 1'b0;
        step(); chk("hr_ack_d", host_ack, 1'b1); chk("hr_rdata", host_rdata, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("hr_held_ack%0d", i), host_ack, 1'b0);
        end
        chk("hr_rdata_held", host_rdata, 16'h1234);
        host_req = 1'b0;
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd9; host_wdata = 16'h9999;
        step(); chk("hw_ack_a", host_ack, 1'b0);
        step(); chk("hw_ack_b", host_ack, 1'b1); chk("hw_rdata_kept", host_rdata, 16'h1234);
        host_req = 1'b0;
        step(); chk("hw_ack_c", host_ack, 1'b0);
        core_read(4'd9, 16'h9999, "hw_mem9");

        // Full clear with idle core
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_busy_start", clear_busy, 1'b1);
        cnt = 0;
        while (clear_busy && cnt < 100) begin
            step();
            cnt++;
        end
        chk("clr_cycles", cnt, 16);
        core_read(4'd0, 16'h0, "clr_mem0");
        core_read(4'd5, 16'h0, "clr_mem5");
        core_read(4'd15, 16'h0, "clr_mem15");
        core_read(4'd9, 16'h0, "clr_mem9");

        // Clear with core writes stalling it and a retrigger that must be ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        step();
        write = 1'b1; address = 4'd1; data_out = 16'h7777;
        step();
        address = 4'd14; data_out = 16'h4444;
        step();
        write = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr2_busy_mid", clear_busy, 1'b1);
        cnt = 5;
        while (clear_busy && cnt < 100) begin
            step();
            cnt++;
        end
        chk("clr2_cycles", cnt, 18);
        core_read(4'd1, 16'h7777, "clr2_mem1_kept");
        core_read(4'd14, 16'h0, "clr2_mem14_zeroed");

        // Reset during a stalled host write and an active clear
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'd2; host_wdata = 16'h2222;
        read = 1'b1; address = 4'd1; clear = 1'b1;
        step();
        clear = 1'b0;
        chk("rst_pre_data_in", data_in, 16'h7777);
        chk("rst_pre_busy", clear_busy, 1'b1);
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_data_in", data_in, 16'h0);
        chk("rst_busy", clear_busy, 1'b0);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_rdata", host_rdata, 16'h0);
        host_req = 1'b0; read = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_ack%0d", i), host_ack, 1'b0);
            chk($sformatf("post_rst_busy%0d", i), clear_busy, 1'b0);
        end
        core_read(4'd2, 16'h0, "rst_host_write_aborted");
        core_read(4'd1, 16'h7777, "rst_mem_kept");
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'd1;
        step(); chk("post_rst_hr_a", host_ack, 1'b0);
        step(); chk("post_rst_hr_b", host_ack, 1'b1); chk("post_rst_rdata", host_rdata, 16'h7777);
        host_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter ADDR_W, default `ADDRESS_SIZE, word address width; depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default `DATA_SIZE, word width.
REQ-003 clock  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 read  input  1  core load request (active 1).
REQ-006 write  input  1  core store request (active 1).
REQ-007 address  input  ADDR_W  core word address.
REQ-008 data_out  input  DATA_W  core store data.
REQ-009 data_in  output  DATA_W  load data returned to core.
REQ-010 host_req  input  1  host access request, level, held until host_ack.
REQ-011 host_we  input  1  host access type: 1 write, 0 read; sampled with host_req.
REQ-012 host_addr  input  ADDR_W  host word address.
REQ-013 host_wdata  input  DATA_W  host write data.
REQ-014 host_ack  output  1  one-cycle host completion pulse.
REQ-015 host_rdata  output  DATA_W  host read data, valid with host_ack and held after.
REQ-016 clear  input  1  start-clear pulse.
REQ-017 clear_busy  output  1  high while the memory clear is in progress.

Function
REQ-018 Core store: when write=1 at an edge, mem[address] SHALL take data_out at that edge.
REQ-019 Core load: when read=1 at an edge, data_in SHALL take mem[address] at that edge (1-cycle latency); data_in SHALL hold otherwise.
REQ-020 read=1 and write=1 together: the write SHALL occur and data_in SHALL take data_out (write-through).
REQ-021 Core port SHALL have absolute priority; it is never stalled or delayed.
REQ-022 Host FSM states: IDLE, ACCESS, ACK, RELEASE.
REQ-023 IDLE->ACCESS when host_req=1; host_we/addr/wdata SHALL be latched on that transition.
REQ-024 ACCESS: the latched access SHALL execute on the first edge where read=0 and write=0, then ->ACK; otherwise remain in ACCESS.
REQ-025 Host read in ACCESS SHALL load host_rdata with mem[latched addr]; host write SHALL update mem[latched addr] and leave host_rdata unchanged.
REQ-026 ACK: host_ack=1 for exactly one cycle, then ->RELEASE.
REQ-027 RELEASE: wait for host_req=0, then ->IDLE; a new request SHALL require host_req to drop first.
REQ-028 Clear: a clear=1 seen while clear_busy=0 SHALL set clear_busy and an ADDR_W-bit index to 0 on the next edge; clear while busy SHALL be ignored.
REQ-029 While busy, each edge with the core port idle and the host FSM not in ACCESS SHALL write 0 to mem[index] and increment index; otherwise index SHALL hold.
REQ-030 When index=2**ADDR_W-1 is zeroed, clear_busy SHALL drop on that edge; the index wraps to 0.
REQ-031 Core accesses during clear SHALL behave per REQ-018..020; words already stored SHALL be overwritten only if not yet reached by the index.
REQ-032 Write priority at one edge: core, then host, then clear; only one source SHALL write per edge.

Reset
REQ-033 reset=0 SHALL immediately force data_in=0, host_rdata=0, host_ack=0, clear_busy=0, index=0, FSM=IDLE, independent of clock.
REQ-034 Memory contents SHALL be unaffected by reset.
REQ-035 Reset mid host access or mid clear SHALL abort it; no host_ack SHALL be issued and the clear SHALL not resume.

Verification
REQ-036 write=1,address=5,data_out=0x1234; next cycle read=1,address=5 -> data_in=0x1234 one edge later.
REQ-037 read=1,write=1,address=3,data_out=0xAB -> data_in=0xAB and mem[3]=0xAB after the edge.
REQ-038 host_req=1,host_we=0,host_addr=5 while core issues reads for 3 cycles -> host_ack pulses 1 cycle, 1 edge after the core goes idle, host_rdata=0x1234.
REQ-039 clear pulse with idle core -> clear_busy high 2**ADDR_W cycles, then reads of addresses 0, 5 and max return 0.
REQ-040 host write in flight, then reset=0 -> host_ack=0, FSM IDLE, clear_busy=0 asynchronously; data_in=0.
REQ-041 host_req held high after host_ack -> no second host_ack until host_req drops and is reasserted.
